// File: rtl/attex_bus_sequencer.sv
// attex_bus_sequencer: SCC68070 main-bus cycle sequencer for the CD-i top level.
// Decodes the CPU address into chip selects, waits for the selected device's
// acknowledge, and returns a registered one-cycle bus_ack with latched read data.
// It raises a one-cycle bus_err on unmapped areas and device timeouts, strobes the
// slave uC IRQ, and counts timeouts and aborted cycles.
//
// Handshake: a CPU cycle is live while cpu_as=1 and at least one data strobe is
// set. cpu_iack4=1 starts an interrupt-acknowledge cycle regardless of the strobes.
// Level devices complete on their ack level. The slave uC completes on a rising
// edge of slave_dtack_n. The sequencer answers each strobe exactly once, with
// cpu_bus_ack or cpu_bus_err high for a single clk30 cycle. It then waits in END
// until cpu_as drops.
//
// dbg_o = {write_q, target_q[2:0], state_q[2:0]} gives visibility of the sequencer.
module attex_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 256,  // 2..65535
    parameter int unsigned SLAVE_IRQ_LEN  = 1     // >= 1
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic        cpu_as,
    input  logic        cpu_uds,
    input  logic        cpu_lds,
    input  logic        cpu_write,
    input  logic [23:1] cpu_addr,
    input  logic        cpu_iack4,
    input  logic        mcd212_ack,
    input  logic        cdic_ack,
    input  logic        mk48_ack,
    input  logic        slave_dtack_n,
    input  logic [15:0] mcd212_dout,
    input  logic [15:0] cdic_dout,
    input  logic [7:0]  mk48_dout,
    input  logic [7:0]  slave_dout,
    output logic        cs_mcd212,
    output logic        cs_dvc,
    output logic        cs_cdic,
    output logic        cs_slave,
    output logic        cs_mk48,
    output logic [15:0] cpu_data_in,
    output logic        cpu_bus_ack,
    output logic        cpu_bus_err,
    output logic        slave_irq,
    output logic [7:0]  timeout_cnt,
    output logic [7:0]  abort_cnt,
    output logic [6:0]  dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_ERR  = 3'd3,
        S_END  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        T_NONE  = 3'd0,
        T_MCD   = 3'd1,
        T_DVC   = 3'd2,
        T_CDIC  = 3'd3,
        T_SLAVE = 3'd4,
        T_MK48  = 3'd5
    } target_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam int unsigned IRQ_W     = $clog2(SLAVE_IRQ_LEN + 1);
    localparam logic [IRQ_W-1:0] IRQ_LOAD = IRQ_W'(SLAVE_IRQ_LEN);

    state_t         state_q, state_d;
    target_t        target_q, target_d;
    logic [15:0]    wait_q, wait_d;
    logic [15:0]    data_q, data_d;
    logic           write_q, write_d;
    logic           dtack_q;
    logic [IRQ_W-1:0] irq_cnt_q;
    logic [7:0]     timeout_cnt_q;
    logic [7:0]     abort_cnt_q;

    // Per-cycle events raised by the next-state logic.
    logic           irq_start;
    logic           timeout_hit;
    logic           abort_hit;

    // Address decode results.
    logic [23:0]    byte_addr;
    target_t        dec_target;
    logic           dec_unmapped;
    logic           dec_default;

    // Completion view of the latched target.
    logic           dev_ack;
    logic [15:0]    dev_data;

    assign byte_addr = {cpu_addr, 1'b0};

    // Address decode in priority order. The unmapped window is tested before
    // the MCD212 window, so 0x600000..0x7FFFFF reports a bus error.
    always_comb begin
        dec_target   = T_NONE;
        dec_unmapped = 1'b0;
        dec_default  = 1'b0;
        if (cpu_as) begin
            if (byte_addr[23:16] == 8'h30) begin
                dec_target = T_CDIC;
            end else if (byte_addr[23:16] == 8'h31) begin
                dec_target = T_SLAVE;
            end else if (byte_addr[23:16] == 8'h32) begin
                dec_target = T_MK48;
            end else if (byte_addr[23:20] == 4'hD || byte_addr[23:19] == 5'b11101) begin
                dec_target = T_DVC;
            end else if ((byte_addr >= 24'h600000 && byte_addr < 24'hD00000) ||
                         byte_addr >= 24'hF00000) begin
                dec_unmapped = 1'b1;
            end else if (byte_addr <= 24'h27FFFF ||
                         (byte_addr >= 24'h400000 && byte_addr < 24'h800000)) begin
                dec_target = T_MCD;
            end else begin
                dec_default = 1'b1;
            end
        end
    end

    // Select the acknowledge and the read data of the latched target.
    // Byte-wide devices are replicated on both data lanes.
    always_comb begin
        dev_ack  = 1'b0;
        dev_data = 16'h0000;
        case (target_q)
            T_MCD, T_DVC: begin
                dev_ack  = mcd212_ack;
                dev_data = mcd212_dout;
            end
            T_CDIC: begin
                dev_ack  = cdic_ack;
                dev_data = cdic_dout;
            end
            T_MK48: begin
                dev_ack  = mk48_ack;
                dev_data = {mk48_dout, mk48_dout};
            end
            T_SLAVE: begin
                dev_ack  = slave_dtack_n & ~dtack_q;
                dev_data = {slave_dout, slave_dout};
            end
            default: begin
                dev_ack  = 1'b0;
                dev_data = 16'h0000;
            end
        endcase
    end

    // Sequencer state register plus the latched cycle context.
    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q  <= S_IDLE;
            target_q <= T_NONE;
            wait_q   <= 16'h0000;
            data_q   <= 16'h0000;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            write_q  <= write_d;
        end
    end

    // Next-state logic: start, wait, complete, time out or abort a bus cycle.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        wait_d      = wait_q;
        data_d      = data_q;
        write_d     = write_q;
        irq_start   = 1'b0;
        timeout_hit = 1'b0;
        abort_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                target_d = T_NONE;
                if (cpu_iack4) begin
                    // The CDIC interrupt vector is returned directly.
                    state_d = S_ACK;
                    data_d  = cdic_dout;
                    write_d = cpu_write;
                end else if (cpu_as && (cpu_uds || cpu_lds)) begin
                    write_d = cpu_write;
                    if (dec_unmapped) begin
                        state_d = S_ERR;
                    end else if (dec_default) begin
                        state_d = S_ACK;
                        data_d  = 16'h0000;
                    end else begin
                        state_d   = S_WAIT;
                        target_d  = dec_target;
                        wait_d    = 16'h0000;
                        irq_start = (dec_target == T_SLAVE);
                    end
                end
            end
            S_WAIT: begin
                wait_d = wait_q + 16'd1;
                if (!cpu_as) begin
                    // The CPU gave up on the cycle. Go back quietly.
                    state_d   = S_IDLE;
                    abort_hit = 1'b1;
                end else if (dev_ack) begin
                    // An ack on the last wait cycle still wins over the timeout.
                    state_d = S_ACK;
                    data_d  = dev_data;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_ERR;
                    timeout_hit = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_END;
            end
            S_ERR: begin
                state_d = S_END;
            end
            S_END: begin
                // Wait here until the strobe is released, so one strobe gets one answer.
                if (!cpu_as) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the registered state: chip selects, ack and err pulses.
    always_comb begin
        cs_mcd212   = 1'b0;
        cs_dvc      = 1'b0;
        cs_cdic     = 1'b0;
        cs_slave    = 1'b0;
        cs_mk48     = 1'b0;
        if (state_q == S_WAIT || state_q == S_ACK || state_q == S_END) begin
            cs_mcd212 = (target_q == T_MCD);
            cs_dvc    = (target_q == T_DVC);
            cs_cdic   = (target_q == T_CDIC);
            cs_slave  = (target_q == T_SLAVE);
            cs_mk48   = (target_q == T_MK48);
        end
        cpu_bus_ack = (state_q == S_ACK);
        cpu_bus_err = (state_q == S_ERR);
    end

    // Track the slave DTACK level for edge detection.
    // Also run the slave IRQ strobe and the saturating event counters.
    always_ff @(posedge clk30) begin
        if (reset) begin
            dtack_q       <= 1'b0;
            irq_cnt_q     <= '0;
            timeout_cnt_q <= 8'h00;
            abort_cnt_q   <= 8'h00;
        end else begin
            dtack_q <= slave_dtack_n;
            if (irq_start) begin
                irq_cnt_q <= IRQ_LOAD;
            end else if (irq_cnt_q != '0) begin
                irq_cnt_q <= irq_cnt_q - IRQ_W'(1);
            end
            if (timeout_hit && timeout_cnt_q != 8'hFF) begin
                timeout_cnt_q <= timeout_cnt_q + 8'd1;
            end
            if (abort_hit && abort_cnt_q != 8'hFF) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end
    end

    assign cpu_data_in = data_q;
    assign slave_irq   = (irq_cnt_q != '0);
    assign timeout_cnt = timeout_cnt_q;
    assign abort_cnt   = abort_cnt_q;
    assign dbg_o       = {write_q, target_q, state_q};

endmodule

// File: tb/tb_attex_bus_sequencer.sv
// Bench for attex_bus_sequencer. Directed bus cycles are scheduled on a cycle
// timeline: each access fills per-cycle expectations from the device latency
// rules, and one compare process checks every output on every cycle.
module tb_attex_bus_sequencer;

  localparam int TMO  = 16;
  localparam int MAXC = 4096;

  localparam int K_MCD   = 0;
  localparam int K_DVC   = 1;
  localparam int K_CDIC  = 2;
  localparam int K_SLAVE = 3;
  localparam int K_MK48  = 4;
  localparam int K_UNM   = 5;
  localparam int K_DEF   = 6;

  // ---------------- clock / reset ----------------
  logic        clk30 = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_as = 1'b0, cpu_uds = 1'b0, cpu_lds = 1'b0, cpu_write = 1'b0;
  logic [23:1] cpu_addr = '0;
  logic        cpu_iack4 = 1'b0;
  logic        mcd212_ack = 1'b0, cdic_ack = 1'b0, mk48_ack = 1'b0, slave_dtack_n = 1'b0;
  logic [15:0] mcd212_dout = '0, cdic_dout = '0;
  logic [7:0]  mk48_dout = '0, slave_dout = '0;
  logic        cs_mcd212, cs_dvc, cs_cdic, cs_slave, cs_mk48;
  logic [15:0] cpu_data_in;
  logic        cpu_bus_ack, cpu_bus_err, slave_irq;
  logic [7:0]  timeout_cnt, abort_cnt;
  logic [6:0]  dbg;

  always #5 clk30 = ~clk30;

  int cyc = 0;
  always @(posedge clk30) cyc <= cyc + 1;

  attex_bus_sequencer #(.TIMEOUT_CYCLES(TMO), .SLAVE_IRQ_LEN(1)) dut (
    .clk30(clk30), .reset(reset),
    .cpu_as(cpu_as), .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_iack4(cpu_iack4),
    .mcd212_ack(mcd212_ack), .cdic_ack(cdic_ack), .mk48_ack(mk48_ack),
    .slave_dtack_n(slave_dtack_n),
    .mcd212_dout(mcd212_dout), .cdic_dout(cdic_dout), .mk48_dout(mk48_dout),
    .slave_dout(slave_dout),
    .cs_mcd212(cs_mcd212), .cs_dvc(cs_dvc), .cs_cdic(cs_cdic), .cs_slave(cs_slave),
    .cs_mk48(cs_mk48), .cpu_data_in(cpu_data_in), .cpu_bus_ack(cpu_bus_ack),
    .cpu_bus_err(cpu_bus_err), .slave_irq(slave_irq), .timeout_cnt(timeout_cnt),
    .abort_cnt(abort_cnt), .dbg_o(dbg)
  );

  // ---------------- model: expected timeline ----------------
  bit        exp_ack_a  [MAXC];
  bit        exp_err_a  [MAXC];
  bit        exp_irq_a  [MAXC];
  bit [4:0]  exp_cs_a   [MAXC];   // {mk48, slave, cdic, dvc, mcd212}
  bit [15:0] exp_dat_a  [MAXC];
  bit        exp_tinc_a [MAXC];
  bit        exp_ainc_a [MAXC];
  bit        exp_clr_a  [MAXC];

  int m_tcnt = 0;
  int m_acnt = 0;

  int total = 0;
  int bad   = 0;
  int n_ack = 0;
  int n_irq = 0;
  int last_ack_cyc = -1;
  int last_err_cyc = -1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Memory map of the CD-i main bus, in byte addresses.
  function automatic int model_decode(input logic [23:0] a);
    int unsigned v;
    v = a;
    if ((v >> 16) == 32'h30) return K_CDIC;
    if ((v >> 16) == 32'h31) return K_SLAVE;
    if ((v >> 16) == 32'h32) return K_MK48;
    if ((v >> 20) == 32'hD || (v >> 19) == 32'h1D) return K_DVC;
    if ((v >= 32'h600000 && v < 32'hD00000) || v >= 32'hF00000) return K_UNM;
    if (v < 32'h280000 || (v >= 32'h400000 && v < 32'h800000)) return K_MCD;
    return K_DEF;
  endfunction

  function automatic logic [15:0] model_data(input int k);
    case (k)
      K_MCD, K_DVC: return mcd212_dout;
      K_CDIC:       return cdic_dout;
      K_MK48:       return {mk48_dout, mk48_dout};
      K_SLAVE:      return {slave_dout, slave_dout};
      default:      return 16'h0000;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk30) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (exp_clr_a[cyc]) begin
        m_tcnt = 0;
        m_acnt = 0;
      end
      if (exp_tinc_a[cyc] && m_tcnt < 255) m_tcnt++;
      if (exp_ainc_a[cyc] && m_acnt < 255) m_acnt++;
      chk("cs", {11'd0, cs_mk48, cs_slave, cs_cdic, cs_dvc, cs_mcd212}, {11'd0, exp_cs_a[cyc]});
      chk("bus_ack", {15'd0, cpu_bus_ack}, {15'd0, exp_ack_a[cyc]});
      chk("bus_err", {15'd0, cpu_bus_err}, {15'd0, exp_err_a[cyc]});
      chk("slave_irq", {15'd0, slave_irq}, {15'd0, exp_irq_a[cyc]});
      chk("timeout_cnt", {8'd0, timeout_cnt}, 16'(m_tcnt));
      chk("abort_cnt", {8'd0, abort_cnt}, 16'(m_acnt));
      if (exp_ack_a[cyc]) chk("ack_data", cpu_data_in, exp_dat_a[cyc]);
      if (cpu_bus_ack) begin
        n_ack++;
        last_ack_cyc = cyc;
      end
      if (cpu_bus_err) last_err_cyc = cyc;
      if (slave_irq) n_irq++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk30);
    #1;
  endtask

  task automatic dev_ack(input int k, input logic v);
    case (k)
      K_MCD, K_DVC: mcd212_ack = v;
      K_CDIC:       cdic_ack = v;
      K_MK48:       mk48_ack = v;
      K_SLAVE:      slave_dtack_n = v;
      default:      ;
    endcase
  endtask

  // Runs one strobe. wait_n is the number of cycles from AS to the device ack.
  // wait_n < 0 means the device never answers. hold_n is the number of cycles
  // AS stays high after the ack/err cycle.
  task automatic access(input logic [23:0] a, input logic wr, input logic [1:0] strb,
                        input logic iack, input int wait_n, input int hold_n,
                        output int s, output int d);
    int k, c, e, errc;
    logic active;
    tick();
    s = cyc;
    cpu_as = 1'b1; cpu_uds = strb[1]; cpu_lds = strb[0];
    cpu_write = wr; cpu_addr = a[23:1]; cpu_iack4 = iack;
    k = model_decode(a);
    active = iack || (strb != 2'b00);
    d = -1;
    errc = -1;
    if (!active) begin
      c = s;
    end else if (iack) begin
      c = s + 1;
      exp_ack_a[c] = 1'b1;
      exp_dat_a[c] = cdic_dout;
    end else if (k == K_UNM) begin
      c = s + 1;
      errc = c;
      exp_err_a[c] = 1'b1;
    end else if (k == K_DEF) begin
      c = s + 1;
      exp_ack_a[c] = 1'b1;
      exp_dat_a[c] = 16'h0000;
    end else begin
      if (k == K_SLAVE) exp_irq_a[s + 1] = 1'b1;
      if (wait_n < 0) begin
        c = s + 1 + TMO;
        errc = c;
        exp_err_a[c] = 1'b1;
        exp_tinc_a[c] = 1'b1;
      end else begin
        d = s + wait_n;
        c = d + 1;
        exp_ack_a[c] = 1'b1;
        exp_dat_a[c] = model_data(k);
      end
    end
    e = c + hold_n;
    if (active && !iack && k <= K_MK48)
      for (int i = s + 1; i <= e; i++)
        if (i != errc) exp_cs_a[i][k] = 1'b1;
    while (cyc < e) begin
      tick();
      if (cyc == d) dev_ack(k, 1'b1);
      else if (d >= 0 && cyc == d + 1 && k != K_SLAVE) dev_ack(k, 1'b0);
    end
    cpu_as = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0; cpu_iack4 = 1'b0; cpu_write = 1'b0;
    slave_dtack_n = 1'b0;
  endtask

  // Starts a device read and drops AS (optionally with reset) after n WAIT cycles.
  task automatic abort_access(input logic [23:0] a, input int n, input logic do_reset);
    int s, k;
    tick();
    s = cyc;
    cpu_as = 1'b1; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_write = 1'b0; cpu_addr = a[23:1];
    k = model_decode(a);
    if (k == K_SLAVE) exp_irq_a[s + 1] = 1'b1;
    for (int i = s + 1; i <= s + n; i++) exp_cs_a[i][k] = 1'b1;
    if (do_reset) exp_clr_a[s + n + 1] = 1'b1;
    else          exp_ainc_a[s + n + 1] = 1'b1;
    while (cyc < s + n) tick();
    cpu_as = 1'b0; cpu_uds = 1'b0; cpu_lds = 1'b0;
    if (do_reset) reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, d, a0, i0;
    repeat (3) tick();
    reset = 1'b0;

    // 1: CDIC read, ack 3 cycles after AS
    cdic_dout = 16'hBEEF;
    access(24'h300000, 1'b0, 2'b11, 1'b0, 3, 3, s, d);
    chk("t1_ack_latency", 16'(last_ack_cyc - d), 16'd1);
    chk("t1_data", cpu_data_in, 16'hBEEF);

    // 2: slave read, DTACK rises 10 cycles later and stays high
    slave_dout = 8'h5A;
    a0 = n_ack;
    i0 = n_irq;
    access(24'h310000, 1'b0, 2'b11, 1'b0, 10, 5, s, d);
    chk("t2_data", cpu_data_in, 16'h5A5A);
    chk("t2_ack_count", 16'(n_ack - a0), 16'd1);
    chk("t2_irq_cycles", 16'(n_irq - i0), 16'd1);

    // 3: write to an unmapped area
    access(24'h600000, 1'b1, 2'b11, 1'b0, 0, 2, s, d);
    chk("t3_err_latency", 16'(last_err_cyc - s), 16'd1);
    chk("t3_dbg_write", {15'd0, dbg[6]}, 16'd1);

    // 4: NVRAM never answers
    mk48_dout = 8'hC3;
    access(24'h320000, 1'b0, 2'b11, 1'b0, -1, 2, s, d);
    chk("t4_err_after_wait", 16'(last_err_cyc - (s + 1)), 16'd16);
    chk("t4_timeout_cnt", {8'd0, timeout_cnt}, 16'd1);

    // 5: interrupt acknowledge, no data strobes
    cdic_dout = 16'h0064;
    access(24'h123456, 1'b0, 2'b00, 1'b1, 0, 2, s, d);
    chk("t5_ack_latency", 16'(last_ack_cyc - s), 16'd1);
    chk("t5_data", cpu_data_in, 16'h0064);

    // map corners and other devices
    mcd212_dout = 16'h1234;
    access(24'h280000, 1'b0, 2'b11, 1'b0, 0, 1, s, d);   // default, data 0
    access(24'hD00000, 1'b0, 2'b10, 1'b0, 2, 2, s, d);   // DVC
    access(24'hE80000, 1'b1, 2'b01, 1'b0, 1, 1, s, d);   // DVC upper window
    access(24'hE00000, 1'b0, 2'b11, 1'b0, 0, 1, s, d);   // default
    access(24'h27FFFE, 1'b0, 2'b11, 1'b0, 1, 1, s, d);   // top of MCD212 window
    access(24'h400000, 1'b0, 2'b11, 1'b0, 4, 1, s, d);   // MCD212 upper window
    access(24'h7FFFFE, 1'b0, 2'b11, 1'b0, 0, 1, s, d);   // unmapped beats MCD212
    access(24'hF00000, 1'b0, 2'b11, 1'b0, 0, 1, s, d);   // unmapped top
    access(24'h300000, 1'b0, 2'b00, 1'b0, 0, 3, s, d);   // no strobes: idle
    cdic_dout = 16'hA55A;
    access(24'h300002, 1'b0, 2'b11, 1'b0, TMO, 1, s, d); // ack on the last wait cycle
    access(24'h320010, 1'b0, 2'b11, 1'b0, 1, 1, s, d);   // NVRAM answers

    // 6: abort in WAIT, then reset during a second WAIT
    abort_access(24'h320000, 4, 1'b0);
    chk("t6_abort_cnt", {8'd0, abort_cnt}, 16'd1);
    abort_access(24'h300000, 5, 1'b1);
    chk("t6_abort_cleared", {8'd0, abort_cnt}, 16'd0);
    chk("t6_timeout_cleared", {8'd0, timeout_cnt}, 16'd0);
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
